mul_pipe_regs: RTL
==================

# mul_pipe_regs

Parametrised register chain for the multiplier pipeline, replacing the hand-written per-boundary M-stage register modules with one block of `NUM_STAGES` register stages. Each stage carries instruction type, PC, result and ROB id plus a valid bit. Stall propagates backwards with bubble collapse, so an empty stage always accepts data even while the output is stalled. The block adds an input-ready handshake, a pipeline-wide flush and an occupancy count, none of which the single-boundary registers have. It sits between the multiplier issue point (M1) and the write-back / ROB-completion arbiter.

## Interface
- `NUM_STAGES`, 4, number of register stages (≥1); default matches the M1→M5 boundaries
- `WORD_SIZE`, `` `WORD_SIZE ``, PC and result width
- `INSTR_TYPE_SZ`, `` `INSTR_TYPE_SZ ``, instruction-type width
- `ROB_ENTRY_WIDTH`, `` `ROB_ENTRY_WIDTH ``, ROB id width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `valid`  in  1  input entry valid
- `instruction_type`  in  INSTR_TYPE_SZ  input payload
- `pc`  in  WORD_SIZE  input payload
- `result`  in  WORD_SIZE  input payload
- `rob_id`  in  ROB_ENTRY_WIDTH  input payload
- `in_ready`  out  1  stage 0 loads this cycle; input is consumed when `valid && in_ready`
- `stall`  in  1  downstream cannot take the last stage's entry
- `flush`  in  1  synchronous kill of every in-flight entry and the current input
- `valid_out`  out  1  last stage valid
- `instruction_type_out`, `pc_out`, `result_out`, `rob_id_out`  out  as inputs  last-stage payload
- `occupancy`  out  $clog2(NUM_STAGES+1)  number of valid stages

## Operation
- State: `v[i]` and `payload[i]` for i = 0..NUM_STAGES-1. Stage NUM_STAGES-1 drives the `*_out` ports.
- Load enables, computed combinationally from the last stage backwards:
  - `load[NUM_STAGES] = !stall`
  - `load[i] = !v[i] || load[i+1]`
- `in_ready = load[0]`. It does not depend on `valid`, and it ignores `flush`.
- On each rising edge when `flush = 0`:
  - Stage 0: if `load[0]`, then `v[0] <= valid` and `payload[0] <= inputs`.
  - Stage i > 0: if `load[i]`, then `v[i] <= v[i-1]` and `payload[i] <= payload[i-1]`.
  - A stage with `load[i] = 0` holds its valid bit and payload.
- On a rising edge when `flush = 1`:
  - All `v[i] <= 0`; the input is dropped even if `in_ready` was 1.
  - Payload registers may update as if `flush = 0`; their values are don't-care while invalid.
- Payload registers are written only when their `load[i]` is 1 (clock-enable, no unconditional copy). A held entry is therefore never overwritten while `stall` is asserted.
- `occupancy` = popcount of `v`, registered and updated on the same edge as `v`. It is never wider than its declared width.

## Timing
- Asynchronous reset assertion clears all `v[i]`, all payloads, `valid_out`, every `*_out` and `occupancy` to 0. Release is synchronised by the usual reset synchroniser outside the block.
- Latency: an entry accepted at edge t appears on `valid_out` after edge t+NUM_STAGES-1, given no stall. Throughput is one entry per cycle.
- `stall` affects only stages that are full from the tail back to the first empty stage. Bubbles ahead of the first empty stage still advance.
- Stall while full: `in_ready = 0` in the same cycle (combinational path from `stall` to `in_ready`). No entry is lost or duplicated.
- Stall released with the pipe full: the whole chain shifts on the same edge, and `in_ready = 1` that cycle.
- `flush` together with `stall`: flush wins and all entries are cleared.
- `flush` together with `valid && in_ready`: the input is discarded and `occupancy` becomes 0.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge.
- NUM_STAGES = 1 degenerates to a single register with `in_ready = !v[0] || !stall`.

## Structure
- `WORD_SIZE`, `INSTR_TYPE_SZ` and `ROB_ENTRY_WIDTH` defaults come from the shared defines/package. Also add a packed struct there for the payload (instruction type, pc, result, rob_id) so downstream stages reuse it.
- The natural sub-module is `pipe_stage_reg`: one valid bit plus payload, with `load` and `flush` inputs and asynchronous active-low reset. Instantiate it NUM_STAGES times in a generate loop. The `load` chain and `occupancy` logic stay in `mul_pipe_regs`.

## Test plan
- Streaming (NUM_STAGES=4): drive rob_id 1..8 on consecutive cycles with `stall=0`.
  - rob_id 1 reaches `valid_out` after the 4th edge, followed by 2..8 on consecutive cycles.
  - `in_ready` stays 1 and `occupancy` reaches 4.
- Stall when full: fill with ids 1..4, then hold `stall=1` for 5 cycles.
  - `valid_out=1`, `rob_id_out` stays 1, `in_ready=0`, `occupancy=4`.
  - Release `stall`: ids 1, 2, 3, 4 emerge in order with no duplicates.
- Bubble collapse: send id 7, two idle cycles, then id 8, and assert `stall` once id 7 reaches the output.
  - id 8 advances to stage 2 while id 7 is held, and `in_ready` stays 1.
  - `occupancy` = 2.
- Flush: flush with 3 entries in flight plus `valid=1` on the input.
  - Next cycle: `valid_out=0` and `occupancy=0`.
  - The next accepted id appears on the output after the 4th edge.
- Async reset: assert `reset=0` between clock edges while the pipe is full.
  - All outputs read 0 before the next edge.
  - After release, the first accepted entry has 4-cycle latency.
- NUM_STAGES=1 elaboration: repeat the stall scenario.
  - `in_ready` = `!valid_out || !stall` on every cycle.

Source files
------------

// File: rtl/mul_pipe_regs_pkg.sv
// Shared widths and payload layout for the multiplier M-stage register chain.
// Downstream write-back logic reuses payload_t to unpack the last stage.
package mul_pipe_regs_pkg;

  localparam int DEFAULT_WORD_SIZE       = 32;
  localparam int DEFAULT_INSTR_TYPE_SZ   = 4;
  localparam int DEFAULT_ROB_ENTRY_WIDTH = 6;

  typedef struct packed {
    logic [DEFAULT_INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [DEFAULT_WORD_SIZE-1:0]       pc;
    logic [DEFAULT_WORD_SIZE-1:0]       result;
    logic [DEFAULT_ROB_ENTRY_WIDTH-1:0] rob_id;
  } payload_t;

  // Flattened payload width for a given parameterisation.
  function automatic int payload_width(input int word_size, input int instr_type_sz,
                                       input int rob_entry_width);
    return instr_type_sz + 2 * word_size + rob_entry_width;
  endfunction

endpackage

// File: rtl/mul_pipe_regs_if.sv
// Bundle between the multiplier issue point, the register chain and write-back.
// master = environment (issue + downstream stall), slave = the register chain.
interface mul_pipe_regs_if
  import mul_pipe_regs_pkg::*;
#(
  parameter int NUM_STAGES      = 4,
  parameter int WORD_SIZE       = DEFAULT_WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = DEFAULT_INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = DEFAULT_ROB_ENTRY_WIDTH
);

  logic                             valid;
  logic [INSTR_TYPE_SZ-1:0]         instruction_type;
  logic [WORD_SIZE-1:0]             pc;
  logic [WORD_SIZE-1:0]             result;
  logic [ROB_ENTRY_WIDTH-1:0]       rob_id;
  logic                             in_ready;
  logic                             stall;
  logic                             flush;
  logic                             valid_out;
  logic [INSTR_TYPE_SZ-1:0]         instruction_type_out;
  logic [WORD_SIZE-1:0]             pc_out;
  logic [WORD_SIZE-1:0]             result_out;
  logic [ROB_ENTRY_WIDTH-1:0]       rob_id_out;
  logic [$clog2(NUM_STAGES+1)-1:0]  occupancy;

  modport master (
    output valid, instruction_type, pc, result, rob_id, stall, flush,
    input  in_ready, valid_out, instruction_type_out, pc_out, result_out, rob_id_out,
           occupancy
  );

  modport slave (
    input  valid, instruction_type, pc, result, rob_id, stall, flush,
    output in_ready, valid_out, instruction_type_out, pc_out, result_out, rob_id_out,
           occupancy
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary: a valid bit plus a clock-enabled payload register.
// flush only kills the valid bit; the payload is don't-care while invalid.
module pipe_stage_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= prev_valid;
      end
      if (load) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/mul_pipe_regs.sv
// NUM_STAGES-deep register chain between M1 and write-back with bubble collapse,
// input-ready handshake, pipeline-wide flush and a registered occupancy count.
module mul_pipe_regs
  import mul_pipe_regs_pkg::*;
#(
  parameter int NUM_STAGES      = 4,
  parameter int WORD_SIZE       = DEFAULT_WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = DEFAULT_INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = DEFAULT_ROB_ENTRY_WIDTH
) (
  input logic           clk,
  input logic           reset,
  mul_pipe_regs_if.slave bus
);

  localparam int PAYLOAD_W = payload_width(WORD_SIZE, INSTR_TYPE_SZ, ROB_ENTRY_WIDTH);
  localparam int OCC_W     = $clog2(NUM_STAGES + 1);

  logic [NUM_STAGES-1:0] load;
  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] v_next;
  logic [NUM_STAGES-1:0] prev_v;
  logic [PAYLOAD_W-1:0]  prev_d [NUM_STAGES];
  logic [PAYLOAD_W-1:0]  data   [NUM_STAGES];
  logic [PAYLOAD_W-1:0]  in_data;
  logic [OCC_W-1:0]      occ_reg;
  logic [OCC_W-1:0]      occ_next;

  assign in_data = {bus.instruction_type, bus.pc, bus.result, bus.rob_id};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      // Unrolled form of load[i] = !v[i] || load[i+1]: a stage moves unless it
      // and everything behind it up to the tail is full while stalled.
      assign load[gi] = !bus.stall || !(&v[NUM_STAGES-1:gi]);

      if (gi == 0) begin : g_head
        assign prev_v[gi] = bus.valid;
        assign prev_d[gi] = in_data;
      end else begin : g_body
        assign prev_v[gi] = v[gi-1];
        assign prev_d[gi] = data[gi-1];
      end

      assign v_next[gi] = !bus.flush && (load[gi] ? prev_v[gi] : v[gi]);

      pipe_stage_reg #(
        .WIDTH (PAYLOAD_W)
      ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .load       (load[gi]),
        .flush      (bus.flush),
        .prev_valid (prev_v[gi]),
        .prev_data  (prev_d[gi]),
        .valid      (v[gi]),
        .data       (data[gi])
      );
    end
  endgenerate

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occ_next = occ_next + OCC_W'(v_next[i]);
    end
  end

  // Counted from the next-state valid vector so it tracks v on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.valid_out = v[NUM_STAGES-1];
  assign {bus.instruction_type_out, bus.pc_out, bus.result_out, bus.rob_id_out} =
         data[NUM_STAGES-1];
  assign bus.occupancy = occ_reg;

endmodule
